// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameters for the FIFO write arbiter.
//   arb_state_t      : arbiter FSM state (IDLE, BURST)
//   DEF_*            : default values for the top-level parameters
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int unsigned DEF_NUM_REQ   = 4;
    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_MAX_BURST = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: returns the first asserted request after i_last.
//   i_req   : request vector
//   i_last  : index with lowest priority; scan starts at i_last+1 and wraps
//   o_valid : at least one request asserted
//   o_idx   : index of the winning request (0 when o_valid=0)
module rr_pick #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [ID_WIDTH-1:0] i_last,
    output logic                o_valid,
    output logic [ID_WIDTH-1:0] o_idx
);

    // Scan offsets 1..NUM_REQ so that i_last itself is checked last.
    always_comb begin
        int unsigned pos;
        logic [ID_WIDTH-1:0] w_pos;
        pos     = 0;
        w_pos   = '0;
        o_valid = 1'b0;
        o_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            pos   = (32'(i_last) + k) % NUM_REQ;
            w_pos = ID_WIDTH'(pos);
            if (!o_valid && i_req[w_pos]) begin
                o_valid = 1'b1;
                o_idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NUM_REQ sources,
// with bounded bursts and source tagging. Never writes while the FIFO is full.
//   clk, rst  : clock; synchronous active-low reset
//   req       : per-requester request, held with data until ack
//   req_data  : requester i data at [i*WIDTH +: WIDTH]
//   full      : FIFO full flag (combinational gate on writes)
//   ack       : one-hot grant, beat written this cycle
//   wr_en     : FIFO write enable (|ack)
//   wdata     : selected data, 0 when idle
//   wsrc      : source index of the write, 0 when idle
//   busy      : arbiter is inside a burst
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST,
    parameter int unsigned ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic                     full,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     wr_en,
    output logic [WIDTH-1:0]         wdata,
    output logic [ID_WIDTH-1:0]      wsrc,
    output logic                     busy
);

    localparam int unsigned         BEAT_W   = $clog2(MAX_BURST + 1);
    localparam logic [ID_WIDTH-1:0] LAST_RST = ID_WIDTH'(NUM_REQ - 1);

    arb_state_t          r_state,  w_state_nxt;
    logic [ID_WIDTH-1:0] r_owner,  w_owner_nxt;
    logic [ID_WIDTH-1:0] r_last,   w_last_nxt;
    logic [BEAT_W-1:0]   r_beats,  w_beats_nxt;

    logic                w_locked;
    logic                w_write;
    logic [ID_WIDTH-1:0] w_cand;
    logic [ID_WIDTH-1:0] w_scan_last;
    logic                w_pick_valid;
    logic [ID_WIDTH-1:0] w_pick_idx;
    logic [NUM_REQ-1:0]  w_ack;
    logic [WIDTH-1:0]    w_wdata;
    logic [ID_WIDTH-1:0] w_wsrc;

    // A burst owner scans from itself, so an expired owner has lowest priority.
    assign w_scan_last = (r_state == BURST) ? r_owner : r_last;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .i_req   (req),
        .i_last  (w_scan_last),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_last  <= LAST_RST;
            r_beats <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_beats <= w_beats_nxt;
        end
    end

    // Grant selection, output mux and next-state.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_beats_nxt = r_beats;
        w_ack       = '0;
        w_wdata     = '0;
        w_wsrc      = '0;

        w_locked = (r_state == BURST) && req[r_owner] && (r_beats < BEAT_W'(MAX_BURST));
        w_cand   = w_locked ? r_owner : w_pick_idx;
        // rst gating keeps every output quiet during reset.
        w_write  = rst && !full && (w_locked || w_pick_valid);

        if (w_write) begin
            w_wsrc = w_cand;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (ID_WIDTH'(i) == w_cand) begin
                    w_ack[i] = 1'b1;
                    w_wdata  = req_data[i*WIDTH +: WIDTH];
                end
            end
        end

        case (r_state)
            IDLE: begin
                if (w_write) begin
                    if (MAX_BURST == 1) begin
                        w_last_nxt = w_cand;
                    end else begin
                        w_state_nxt = BURST;
                        w_owner_nxt = w_cand;
                        w_beats_nxt = BEAT_W'(1);
                    end
                end
            end
            BURST: begin
                if (w_locked) begin
                    // Stalled cycles (full) leave the beat count alone.
                    if (w_write) begin
                        w_beats_nxt = r_beats + BEAT_W'(1);
                    end
                end else begin
                    // Release; a same-cycle grant starts the next burst with no bubble.
                    w_last_nxt = r_owner;
                    if (w_write) begin
                        w_owner_nxt = w_cand;
                        w_beats_nxt = BEAT_W'(1);
                    end else begin
                        w_state_nxt = IDLE;
                        w_beats_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign ack   = w_ack;
    assign wr_en = |w_ack;
    assign wdata = w_wdata;
    assign wsrc  = w_wsrc;
    assign busy  = rst && (r_state == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter (NUM_REQ=4, WIDTH=8, MAX_BURST=4).
// Stimulus pushes one expected-output record per cycle; the monitor pops and
// compares on the falling edge.
module tb_fifo_wr_arbiter;

    typedef struct {
        logic       wr;
        logic [1:0] src;
        logic       busy;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        full;
    logic [3:0]  ack;
    logic        wr_en;
    logic [7:0]  wdata;
    logic [1:0]  wsrc;
    logic        busy;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass   = 0;

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .WIDTH     (8),
        .MAX_BURST (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .full     (full),
        .ack      (ack),
        .wr_en    (wr_en),
        .wdata    (wdata),
        .wsrc     (wsrc),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] dat(input logic [1:0] i);
        case (i)
            2'd0:    return 8'hA0;
            2'd1:    return 8'hB1;
            2'd2:    return 8'hC2;
            default: return 8'hD3;
        endcase
    endfunction

    // Drive one cycle of inputs and queue the expected response for it.
    task automatic step(input logic r, input logic [3:0] rq, input logic f,
                        input logic ew, input logic [1:0] es, input logic eb);
        exp_t x;
        @(posedge clk);
        #1;
        rst  = r;
        req  = rq;
        full = f;
        x.wr   = ew;
        x.src  = es;
        x.busy = eb;
        exp_q.push_back(x);
    endtask

    // Monitor: compare DUT outputs against the head of the scoreboard.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [3:0] ea;
            logic [7:0] ed;
            logic [1:0] es;
            e  = exp_q.pop_front();
            ea = e.wr ? (4'b0001 << e.src) : 4'b0000;
            ed = e.wr ? dat(e.src) : 8'h00;
            es = e.wr ? e.src : 2'd0;
            n_checks++;
            if (ack === ea && wr_en === e.wr && wdata === ed && wsrc === es) begin
                n_pass++;
            end else begin
                $display("FAIL out @%0t: ack=%b wr_en=%b wdata=%h wsrc=%0d, expected ack=%b wr_en=%b wdata=%h wsrc=%0d",
                         $time, ack, wr_en, wdata, wsrc, ea, e.wr, ed, es);
            end
            n_checks++;
            if (busy === e.busy) begin
                n_pass++;
            end else begin
                $display("FAIL busy @%0t: busy=%b expected %b", $time, busy, e.busy);
            end
        end else if (wr_en !== 1'b0) begin
            n_checks++;
            $display("FAIL unexpected_write @%0t: wr_en=%b wsrc=%0d with no expectation", $time, wr_en, wsrc);
        end
    end

    initial begin
        rst      = 1'b0;
        req      = 4'b0000;
        full     = 1'b0;
        req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

        // Reset held with all requesters asking: nothing may be written.
        step(1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
        step(1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);

        // Full rotation: 4 beats each in order 0,1,2,3, no gaps.
        for (int c = 0; c < 16; c++) begin
            step(1'b1, 4'b1111, 1'b0, 1'b1, 2'(c / 4), (c == 0) ? 1'b0 : 1'b1);
        end
        step(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);   // owner 3 expired, release to IDLE

        // Early release: req[2] drops after 2 acks while req[3] rises.
        step(1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
        step(1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b1);
        step(1'b1, 4'b1000, 1'b0, 1'b1, 2'd3, 1'b1);
        step(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
        step(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

        // Backpressure on owner 1 at beats=2; req[0] waits behind it.
        step(1'b1, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
        step(1'b1, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 4'b0011, 1'b1, 1'b0, 2'd0, 1'b1);
        end
        step(1'b1, 4'b0011, 1'b0, 1'b1, 2'd1, 1'b1);
        step(1'b1, 4'b0011, 1'b0, 1'b1, 2'd1, 1'b1);
        step(1'b1, 4'b0011, 1'b0, 1'b1, 2'd0, 1'b1);   // handoff to 0
        step(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
        step(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

        // Sole requester: 10 back-to-back acks across burst expiries.
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, (c == 0) ? 1'b0 : 1'b1);
        end
        step(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
        step(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

        // Mid-burst reset while 3 owns the port; priority returns to 0 side.
        step(1'b1, 4'b1000, 1'b0, 1'b1, 2'd3, 1'b0);
        step(1'b1, 4'b1000, 1'b0, 1'b1, 2'd3, 1'b1);
        step(1'b0, 4'b1000, 1'b0, 1'b0, 2'd0, 1'b0);
        step(1'b1, 4'b1010, 1'b0, 1'b1, 2'd1, 1'b0);
        step(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
        step(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

        // Drain the scoreboard with a bounded wait.
        for (int c = 0; c < 4 && exp_q.size() > 0; c++) begin
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
